// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg : shared widths, constants and FSM encoding for the writeback arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_pkg;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    WB_NORMAL = 1'b0,
    WB_DRAIN  = 1'b1
  } wb_state_t;
endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo : synchronous FIFO with per-entry valid/address view for pend_mask
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [AW-1:0]              head_addr,
  output logic [DW-1:0]              head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH-1:0][AW-1:0]   ent_addr
);
  import wb_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [DEPTH-1:0][DW-1:0]  data_q;
  logic                      do_push;
  logic                      do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign head_addr = ent_addr[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ent_valid <= '0;
      ent_addr  <= '0;
      data_q    <= '0;
    end else begin
      if (do_push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_addr[wr_ptr]  <= push_addr;
        data_q[wr_ptr]    <= push_data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter : merges pipeline and mult/div results onto the single RF write
// port; optional write-through forwarding enabled by macro WB_FWD_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int DW         = wb_pkg::DW,
  parameter int AW         = wb_pkg::AW
) (
  input  logic                          WB_CLK,
  input  logic                          WB_RST_N,
  input  logic                          s0_valid,
  output logic                          s0_ready,
  input  logic [AW-1:0]                 s0_addr,
  input  logic [DW-1:0]                 s0_data,
  input  logic                          s1_valid,
  output logic                          s1_ready,
  input  logic [AW-1:0]                 s1_addr,
  input  logic [DW-1:0]                 s1_data,
  output logic                          rf_w,
  output logic [AW-1:0]                 rf_waddr,
  output logic [DW-1:0]                 rf_wdata,
  output logic [wb_pkg::NREG-1:0]       pend_mask,
`ifdef WB_FWD_EN
  input  logic [AW-1:0]                 rsc,
  input  logic [AW-1:0]                 rtc,
  output logic                          fwd_rs_hit,
  output logic                          fwd_rt_hit,
  output logic [DW-1:0]                 fwd_rs_data,
  output logic [DW-1:0]                 fwd_rt_data,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
  import wb_pkg::*;

  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0]  ADDR_ZERO = AW'(REG_ZERO);

  wb_state_t                      state;
  wb_state_t                      state_nxt;
  logic                           fifo_empty;
  logic                           fifo_full;
  logic                           fifo_push;
  logic                           fifo_pop;
  logic [AW-1:0]                  head_addr;
  logic [DW-1:0]                  head_data;
  logic [FIFO_DEPTH-1:0]          ent_valid;
  logic [FIFO_DEPTH-1:0][AW-1:0]  ent_addr;
  logic [NREG-1:0]                pend_fifo;
  logic [NREG-1:0]                out_bit;
  logic                           s0_issue;
  logic [CW-1:0]                  cnt_nxt;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk       (WB_CLK),
    .rst_n     (WB_RST_N),
    .push      (fifo_push),
    .push_addr (s1_addr),
    .push_data (s1_data),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .cnt       (fifo_cnt),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  // Writes to r0 complete the handshake but never reach the RF or FIFO.
  assign s0_issue  = s0_valid && s0_ready && (s0_addr != ADDR_ZERO);
  assign fifo_push = s1_valid && s1_ready && (s1_addr != ADDR_ZERO);
  assign cnt_nxt   = fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);

  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) state <= WB_NORMAL;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WB_NORMAL: if (cnt_nxt == CW'(FIFO_DEPTH)) state_nxt = WB_DRAIN;
      WB_DRAIN:  if (cnt_nxt == '0)              state_nxt = WB_NORMAL;
      default:   state_nxt = WB_NORMAL;
    endcase
  end

  // s0 is held off while an older buffered write targets the same register.
  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    fifo_pop = 1'b0;
    case (state)
      WB_NORMAL: begin
        s0_ready = !(pend_fifo[s0_addr] && (s0_addr != ADDR_ZERO));
        s1_ready = !fifo_full;
        fifo_pop = !fifo_empty && !(s0_valid && s0_ready && (s0_addr != ADDR_ZERO));
      end
      WB_DRAIN: fifo_pop = !fifo_empty;
      default: ;
    endcase
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      rf_w     <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (s0_issue) begin
      rf_w     <= 1'b1;
      rf_waddr <= s0_addr;
      rf_wdata <= s0_data;
    end else if (fifo_pop) begin
      rf_w     <= 1'b1;
      rf_waddr <= head_addr;
      rf_wdata <= head_data;
    end else begin
      rf_w     <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end
  end

  always_comb begin
    pend_fifo = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i]) pend_fifo[ent_addr[i]] = 1'b1;
    end
  end

  assign out_bit   = rf_w ? (NREG'(1) << rf_waddr) : '0;
  assign pend_mask = pend_fifo | out_bit;

`ifdef WB_FWD_EN
  assign fwd_rs_hit  = rf_w && (rf_waddr == rsc) && (rsc != ADDR_ZERO);
  assign fwd_rt_hit  = rf_w && (rf_waddr == rtc) && (rtc != ADDR_ZERO);
  assign fwd_rs_data = fwd_rs_hit ? rf_wdata : '0;
  assign fwd_rt_data = fwd_rt_hit ? rf_wdata : '0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter : directed self-checking bench for wb_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;
  logic        WB_CLK;
  logic        WB_RST_N;
  logic        s0_valid;
  logic        s0_ready;
  logic [4:0]  s0_addr;
  logic [31:0] s0_data;
  logic        s1_valid;
  logic        s1_ready;
  logic [4:0]  s1_addr;
  logic [31:0] s1_data;
  logic        rf_w;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_cnt;
`ifdef WB_FWD_EN
  logic [4:0]  rsc;
  logic [4:0]  rtc;
  logic        fwd_rs_hit;
  logic        fwd_rt_hit;
  logic [31:0] fwd_rs_data;
  logic [31:0] fwd_rt_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rf_model [32];

  wb_arbiter #(.FIFO_DEPTH(4), .DW(32), .AW(5)) dut (
    .WB_CLK      (WB_CLK),
    .WB_RST_N    (WB_RST_N),
    .s0_valid    (s0_valid),
    .s0_ready    (s0_ready),
    .s0_addr     (s0_addr),
    .s0_data     (s0_data),
    .s1_valid    (s1_valid),
    .s1_ready    (s1_ready),
    .s1_addr     (s1_addr),
    .s1_data     (s1_data),
    .rf_w        (rf_w),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .pend_mask   (pend_mask),
`ifdef WB_FWD_EN
    .rsc         (rsc),
    .rtc         (rtc),
    .fwd_rs_hit  (fwd_rs_hit),
    .fwd_rt_hit  (fwd_rt_hit),
    .fwd_rs_data (fwd_rs_data),
    .fwd_rt_data (fwd_rt_data),
`endif
    .fifo_cnt    (fifo_cnt)
  );

  initial WB_CLK = 1'b0;
  always #5 WB_CLK = ~WB_CLK;

  // Register-file model: commits whatever the write port presents at each edge.
  always @(posedge WB_CLK) begin
    if (rf_w) rf_model[rf_waddr] <= rf_wdata;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge WB_CLK);
    #1;
  endtask

  task automatic idle_inputs;
    s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
    s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      s0_valid = 1'b1; s0_addr = 5'(10 + i); s0_data = 32'h100 + i;
      s1_valid = 1'b1; s1_addr = 5'(20 + i); s1_data = 32'h200 + i;
      tick();
    end
    idle_inputs();
    n_checks++;
    if (fifo_cnt !== 3'd3) begin n_fail++; $display("FAIL reset_preload cnt: got %0d expected 3", fifo_cnt); end
    #2 WB_RST_N = 1'b0;
    #1;
    n_checks++;
    if (rf_w !== 1'b0) begin n_fail++; $display("FAIL reset rf_w: got %0b expected 0", rf_w); end
    n_checks++;
    if (rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset rf_addr/data: got %0h/%0h expected 0/0", rf_waddr, rf_wdata); end
    n_checks++;
    if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL reset fifo_cnt: got %0d expected 0", fifo_cnt); end
    n_checks++;
    if (pend_mask !== 32'h0) begin n_fail++; $display("FAIL reset pend_mask: got %h expected 0", pend_mask); end
    #1 WB_RST_N = 1'b1;
    tick();
    s0_valid = 1'b1; s0_addr = 5'd20; s0_data = 32'h0;
    #1;
    n_checks++;
    if (s1_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset s1_ready: got %0b expected 1", s1_ready); end
    n_checks++;
    if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset s0_ready: got %0b expected 1", s0_ready); end
    idle_inputs();
    tick();
  endtask

  task automatic test_s0_only;
    s0_valid = 1'b1; s0_addr = 5'd8; s0_data = 32'h00001234;
    #1;
    n_checks++;
    if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL s0_only ready: got %0b expected 1", s0_ready); end
    tick();
    s0_addr = 5'd0; s0_data = 32'h0000FFFF;
    #1;
    n_checks++;
    if (rf_w !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h00001234)
      begin n_fail++; $display("FAIL s0_only write: got w=%0b a=%0d d=%h expected w=1 a=8 d=00001234", rf_w, rf_waddr, rf_wdata); end
    n_checks++;
    if (pend_mask !== 32'h00000100) begin n_fail++; $display("FAIL s0_only pend: got %h expected 00000100", pend_mask); end
    n_checks++;
    if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL s0_r0 ready: got %0b expected 1", s0_ready); end
    tick();
    idle_inputs();
    n_checks++;
    if (rf_w !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0)
      begin n_fail++; $display("FAIL s0_r0 dropped: got w=%0b a=%0d d=%h expected 0/0/0", rf_w, rf_waddr, rf_wdata); end
    n_checks++;
    if (pend_mask !== 32'h0 || fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL s0_r0 pend/cnt: got %h/%0d expected 0/0", pend_mask, fifo_cnt); end
  endtask

  task automatic test_collision;
    s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'hA;
    s1_valid = 1'b1; s1_addr = 5'd4; s1_data = 32'hB;
    tick();
    idle_inputs();
    n_checks++;
    if (rf_w !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA)
      begin n_fail++; $display("FAIL collision k1 write: got w=%0b a=%0d d=%h expected 1/3/a", rf_w, rf_waddr, rf_wdata); end
    n_checks++;
    if (fifo_cnt !== 3'd1 || pend_mask !== 32'h18) begin n_fail++; $display("FAIL collision k1 cnt/pend: got %0d/%h expected 1/18", fifo_cnt, pend_mask); end
    tick();
    n_checks++;
    if (rf_w !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hB)
      begin n_fail++; $display("FAIL collision k2 write: got w=%0b a=%0d d=%h expected 1/4/b", rf_w, rf_waddr, rf_wdata); end
    n_checks++;
    if (fifo_cnt !== 3'd0 || pend_mask !== 32'h10) begin n_fail++; $display("FAIL collision k2 cnt/pend: got %0d/%h expected 0/10", fifo_cnt, pend_mask); end
    tick();
    n_checks++;
    if (rf_w !== 1'b0 || pend_mask !== 32'h0) begin n_fail++; $display("FAIL collision k3 idle: got w=%0b pend=%h expected 0/0", rf_w, pend_mask); end
  endtask

  task automatic test_full_drain;
    for (int i = 0; i < 4; i++) begin
      s0_valid = 1'b1; s0_addr = 5'(1 + i);  s0_data = 32'h100 + i;
      s1_valid = 1'b1; s1_addr = 5'(16 + i); s1_data = 32'h200 + i;
      #1;
      n_checks++;
      if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin n_fail++; $display("FAIL fill%0d ready: got %0b/%0b expected 1/1", i, s0_ready, s1_ready); end
      tick();
    end
    s0_addr = 5'd30; s0_data = 32'hDEAD;
    s1_addr = 5'd31; s1_data = 32'hBEEF;
    #1;
    n_checks++;
    if (fifo_cnt !== 3'd4 || pend_mask !== 32'h000F0010) begin n_fail++; $display("FAIL full cnt/pend: got %0d/%h expected 4/000f0010", fifo_cnt, pend_mask); end
    n_checks++;
    if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL drain ready: got %0b/%0b expected 0/0", s0_ready, s1_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (rf_w !== 1'b1 || rf_waddr !== 5'(16 + i) || rf_wdata !== 32'h200 + i)
        begin n_fail++; $display("FAIL drain pop%0d: got w=%0b a=%0d d=%h expected 1/%0d/%h", i, rf_w, rf_waddr, rf_wdata, 16 + i, 32'h200 + i); end
      n_checks++;
      if (i < 3) begin
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL drain%0d ready: got %0b/%0b expected 0/0", i, s0_ready, s1_ready); end
      end else begin
        if (s0_ready !== 1'b1 || s1_ready !== 1'b1 || fifo_cnt !== 3'd0)
          begin n_fail++; $display("FAIL drain exit: got r0=%0b r1=%0b cnt=%0d expected 1/1/0", s0_ready, s1_ready, fifo_cnt); end
      end
    end
    idle_inputs();
    tick();
    n_checks++;
    if (rf_w !== 1'b0 || fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL drain idle: got w=%0b cnt=%0d expected 0/0", rf_w, fifo_cnt); end
  endtask

  task automatic test_ordering;
    s1_valid = 1'b1; s1_addr = 5'd5; s1_data = 32'h11;
    tick();
    s1_valid = 1'b0;
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h22;
    #1;
    n_checks++;
    if (s0_ready !== 1'b0) begin n_fail++; $display("FAIL order hold ready: got %0b expected 0", s0_ready); end
    n_checks++;
    if (pend_mask !== 32'h20) begin n_fail++; $display("FAIL order pend: got %h expected 00000020", pend_mask); end
    tick();
    n_checks++;
    if (rf_w !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11)
      begin n_fail++; $display("FAIL order first: got w=%0b a=%0d d=%h expected 1/5/11", rf_w, rf_waddr, rf_wdata); end
    n_checks++;
    if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL order release ready: got %0b expected 1", s0_ready); end
    tick();
    idle_inputs();
    n_checks++;
    if (rf_w !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h22)
      begin n_fail++; $display("FAIL order second: got w=%0b a=%0d d=%h expected 1/5/22", rf_w, rf_waddr, rf_wdata); end
    tick();
    n_checks++;
    if (rf_model[5] !== 32'h22) begin n_fail++; $display("FAIL order final r5: got %h expected 00000022", rf_model[5]); end
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd;
    s0_valid = 1'b1; s0_addr = 5'd9; s0_data = 32'hCAFE;
    tick();
    idle_inputs();
    rsc = 5'd9; rtc = 5'd0;
    #1;
    n_checks++;
    if (fwd_rs_hit !== 1'b1 || fwd_rs_data !== 32'hCAFE)
      begin n_fail++; $display("FAIL fwd rs: got hit=%0b d=%h expected 1/cafe", fwd_rs_hit, fwd_rs_data); end
    n_checks++;
    if (fwd_rt_hit !== 1'b0 || fwd_rt_data !== 32'h0)
      begin n_fail++; $display("FAIL fwd rt: got hit=%0b d=%h expected 0/0", fwd_rt_hit, fwd_rt_data); end
    tick();
    n_checks++;
    if (fwd_rs_hit !== 1'b0 || fwd_rs_data !== 32'h0)
      begin n_fail++; $display("FAIL fwd idle: got hit=%0b d=%h expected 0/0", fwd_rs_hit, fwd_rs_data); end
    rsc = '0;
  endtask
`endif

  initial begin
    WB_RST_N = 1'b0;
    idle_inputs();
`ifdef WB_FWD_EN
    rsc = '0;
    rtc = '0;
`endif
    repeat (2) @(posedge WB_CLK);
    #1 WB_RST_N = 1'b1;
    tick();
    test_reset();
    test_s0_only();
    test_collision();
    test_full_drain();
    test_ordering();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
